// File: rtl/buf_ram_1p_64x64_arb.sv
// Two-requester round-robin arbiter/sequencer in front of one single-port 64-word RAM.
// Supports burst locking, bounded by a starvation counter, and returns tagged read data one cycle after issue.
`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif

module buf_ram_1p_64x64_arb #(
    parameter int AW        = 6,
    parameter int DW        = `PIXEL_WIDTH*8,
    parameter int MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic          a_lock,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic          a_rvalid,
    input  logic          b_req,
    input  logic          b_we,
    input  logic          b_lock,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic          b_rvalid,
    output logic [DW-1:0] rdata,
    output logic          ram_ce,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data_i,
    input  logic [DW-1:0] ram_data_o
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

    typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_t;

    owner_t     owner, owner_nxt;
    logic       rr_last_b;      // 1: B received the most recent grant
    logic [3:0] burst_cnt, burst_nxt;
    logic       grant_a, grant_b, contend;

    assign contend = a_req & b_req;

    // Grant decision. Everything is forced low while reset is held.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!rst) begin
            if (a_req && !b_req)
                grant_a = 1'b1;
            else if (b_req && !a_req)
                grant_b = 1'b1;
            else if (contend) begin
                case (owner)
                    OWN_A:   if (burst_cnt < MAX_CNT) grant_a = 1'b1; else grant_b = 1'b1;
                    OWN_B:   if (burst_cnt < MAX_CNT) grant_b = 1'b1; else grant_a = 1'b1;
                    default: if (rr_last_b) grant_a = 1'b1; else grant_b = 1'b1;
                endcase
            end
        end
    end

    always_comb begin
        a_ack      = grant_a;
        b_ack      = grant_b;
        ram_ce     = grant_a | grant_b;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_data_i = '0;
        if (grant_a) begin
            ram_we     = a_we;
            ram_addr   = a_addr;
            ram_data_i = a_wdata;
        end else if (grant_b) begin
            ram_we     = b_we;
            ram_addr   = b_addr;
            ram_data_i = b_wdata;
        end
    end

    // The grant that establishes a contended lock already counts toward the burst,
    // so the owner gets exactly MAX_BURST grants while the other side waits.
    always_comb begin
        owner_nxt = OWN_NONE;
        burst_nxt = '0;
        if (grant_a && a_lock)
            owner_nxt = OWN_A;
        else if (grant_b && b_lock)
            owner_nxt = OWN_B;
        if (owner_nxt != OWN_NONE) begin
            if (owner_nxt != owner)
                burst_nxt = contend ? 4'd1 : 4'd0;
            else if (contend && burst_cnt != MAX_CNT)
                burst_nxt = burst_cnt + 4'd1;
            else
                burst_nxt = burst_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner     <= OWN_NONE;
            burst_cnt <= '0;
            rr_last_b <= 1'b1;
            a_rvalid  <= 1'b0;
            b_rvalid  <= 1'b0;
        end else begin
            owner     <= owner_nxt;
            burst_cnt <= burst_nxt;
            if (grant_a | grant_b)
                rr_last_b <= grant_b;
            a_rvalid  <= grant_a & ~a_we;
            b_rvalid  <= grant_b & ~b_we;
        end
    end

    assign rdata = ram_data_o;

endmodule

// File: tb/tb_buf_ram_1p_64x64_arb.sv
// Bench for buf_ram_1p_64x64_arb: directed scenarios plus randomized traffic checked against a behavioural model.
module tb_buf_ram_1p_64x64_arb;
    localparam int AW = 6, DW = 64, MAXB = 8;

    logic clk = 1'b0, rst = 1'b1;
    logic a_req = 0, a_we = 0, a_lock = 0, b_req = 0, b_we = 0, b_lock = 0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic a_ack, a_rvalid, b_ack, b_rvalid, ram_ce, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] rdata, ram_data_i, ram_data_o;

    int total = 0, bad = 0;
    logic [DW-1:0] mem [64];
    logic [DW-1:0] ref_mem [64];
    // model: owner 0=none 1=A 2=B; last 1=A 2=B
    int m_owner, m_last, m_cnt;
    bit exp_av, exp_bv;
    logic [DW-1:0] exp_rd;

    buf_ram_1p_64x64_arb #(.AW(AW), .DW(DW), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rvalid(b_rvalid),
        .rdata(rdata), .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_data_i(ram_data_i), .ram_data_o(ram_data_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_we) mem[ram_addr] <= ram_data_i;
            else        ram_data_o <= mem[ram_addr];
        end
    end

    function automatic int predict();
        if (rst) return 0;
        if (a_req && !b_req) return 1;
        if (b_req && !a_req) return 2;
        if (!a_req) return 0;
        if (m_owner == 0) return (m_last == 1) ? 2 : 1;
        if (m_cnt < MAXB) return m_owner;
        return 3 - m_owner;
    endfunction

    task automatic model_reset();
        m_owner = 0; m_last = 2; m_cnt = 0; exp_av = 0; exp_bv = 0;
    endtask

    // Advance one clock, updating the model from the inputs present before the edge.
    task automatic tick();
        int w; bit ow; bit lk; int nown;
        w = predict();
        if (rst) begin
            model_reset();
        end else begin
            exp_av = (w == 1) && !a_we;
            exp_bv = (w == 2) && !b_we;
            if (w == 1) begin if (a_we) ref_mem[a_addr] = a_wdata; else exp_rd = ref_mem[a_addr]; end
            if (w == 2) begin if (b_we) ref_mem[b_addr] = b_wdata; else exp_rd = ref_mem[b_addr]; end
            ow = (w == 1 && b_req) || (w == 2 && a_req);
            lk = (w == 1) ? a_lock : (w == 2) ? b_lock : 1'b0;
            nown = lk ? w : 0;
            if (nown == 0) m_cnt = 0;
            else if (nown != m_owner) m_cnt = ow ? 1 : 0;
            else if (ow && m_cnt < MAXB) m_cnt++;
            m_owner = nown;
            if (w != 0) m_last = w;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        a_req = 0; a_we = 0; a_lock = 0; b_req = 0; b_we = 0; b_lock = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        a_req = 1; a_we = 1; a_addr = 6'd9; a_wdata = 64'hdead; b_req = 1; b_addr = 6'd4;
        #1;
        total++; if (a_ack !== 1'b0 || b_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got a=%b b=%b want 0 0", a_ack, b_ack); end
        total++; if (ram_ce !== 1'b0 || ram_we !== 1'b0) begin bad++; $display("FAIL reset_ce got ce=%b we=%b want 0 0", ram_ce, ram_we); end
        total++; if (ram_addr !== '0 || ram_data_i !== '0) begin bad++; $display("FAIL reset_bus got addr=%0d data=%h want 0 0", ram_addr, ram_data_i); end
        tick();
        total++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got %b%b want 00", a_rvalid, b_rvalid); end
        idle();
        rst = 0;
    endtask

    task automatic test_single_read();
        logic [DW-1:0] want;
        a_req = 1; a_we = 0; a_addr = 6'd5;
        want = ref_mem[5];
        #1;
        total++; if (a_ack !== 1'b1 || b_ack !== 1'b0) begin bad++; $display("FAIL single_ack got a=%b b=%b want 1 0", a_ack, b_ack); end
        total++; if (ram_ce !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 6'd5) begin bad++; $display("FAIL single_pins got ce=%b we=%b addr=%0d want 1 0 5", ram_ce, ram_we, ram_addr); end
        tick();
        idle();
        total++; if (a_rvalid !== 1'b1 || rdata !== want) begin bad++; $display("FAIL single_rdata got v=%b d=%h want 1 %h", a_rvalid, rdata, want); end
    endtask

    task automatic test_alternate();
        do_reset();
        a_req = 1; a_addr = 6'd3; b_req = 1; b_addr = 6'd12;
        for (int i = 0; i < 6; i++) begin
            #1;
            total++; if (a_ack !== (i % 2 == 0) || b_ack !== (i % 2 == 1)) begin bad++; $display("FAIL alt_ack cycle %0d got a=%b b=%b", i, a_ack, b_ack); end
            total++; if (ram_ce !== 1'b1) begin bad++; $display("FAIL alt_ce cycle %0d got %b want 1", i, ram_ce); end
            if (i > 0) begin
                total++;
                if (a_rvalid !== (i % 2 == 1) || b_rvalid !== (i % 2 == 0) || rdata !== ref_mem[(i % 2 == 1) ? 3 : 12]) begin
                    bad++; $display("FAIL alt_rdata cycle %0d got av=%b bv=%b d=%h", i, a_rvalid, b_rvalid, rdata);
                end
            end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_wrap();
        a_req = 1; a_we = 1; a_addr = 6'd63; a_wdata = 64'h1122334455667788;
        #1;
        total++; if (a_ack !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 6'd63 || ram_data_i !== 64'h1122334455667788) begin
            bad++; $display("FAIL wrap_write got ack=%b we=%b addr=%0d data=%h", a_ack, ram_we, ram_addr, ram_data_i); end
        tick();
        idle();
        b_req = 1; b_we = 0; b_addr = 6'd63;
        #1;
        total++; if (b_ack !== 1'b1 || a_ack !== 1'b0) begin bad++; $display("FAIL wrap_read_ack got a=%b b=%b want 0 1", a_ack, b_ack); end
        total++; if (a_rvalid !== 1'b0) begin bad++; $display("FAIL wrap_no_rvalid_on_write got %b want 0", a_rvalid); end
        tick();
        idle();
        total++; if (b_rvalid !== 1'b1 || rdata !== 64'h1122334455667788) begin bad++; $display("FAIL wrap_rdata got v=%b d=%h want 1 1122334455667788", b_rvalid, rdata); end
    endtask

    task automatic test_burst();
        a_req = 1; a_we = 0; a_lock = 1; a_addr = 6'd1;
        b_req = 1; b_we = 0; b_lock = 0; b_addr = 6'd2;
        for (int i = 0; i < 9; i++) begin
            #1;
            total++; if (a_ack !== (i < 8) || b_ack !== (i == 8)) begin bad++; $display("FAIL burst_ack cycle %0d got a=%b b=%b", i, a_ack, b_ack); end
            tick();
        end
        // lock cleared: the next tie goes to A as the round-robin pick
        #1;
        total++; if (a_ack !== 1'b1 || b_ack !== 1'b0) begin bad++; $display("FAIL burst_release got a=%b b=%b want 1 0", a_ack, b_ack); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_owner_drop();
        b_req = 1; b_lock = 1; b_addr = 6'd20;
        #1;
        total++; if (b_ack !== 1'b1) begin bad++; $display("FAIL drop_lock_grant got b=%b want 1", b_ack); end
        tick();
        b_req = 0; b_lock = 0;
        a_req = 1; a_addr = 6'd21;
        #1;
        total++; if (a_ack !== 1'b1 || b_ack !== 1'b0) begin bad++; $display("FAIL drop_switch got a=%b b=%b want 1 0", a_ack, b_ack); end
        tick();
        b_req = 1;
        #1;
        total++; if (b_ack !== 1'b1 || a_ack !== 1'b0) begin bad++; $display("FAIL drop_rr got a=%b b=%b want 0 1", a_ack, b_ack); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_random();
        bit a_hold = 0, b_hold = 0;
        int w;
        for (int i = 0; i < 600; i++) begin
            if (!a_hold) begin
                a_req = ($urandom_range(0, 3) != 0); a_we = 1'($urandom_range(0, 1)); a_lock = ($urandom_range(0, 2) != 0);
                a_addr = AW'($urandom_range(0, 7)); a_wdata = {$urandom, $urandom};
            end
            if (!b_hold) begin
                b_req = ($urandom_range(0, 3) != 0); b_we = 1'($urandom_range(0, 1)); b_lock = ($urandom_range(0, 2) != 0);
                b_addr = AW'($urandom_range(0, 7)); b_wdata = {$urandom, $urandom};
            end
            #1;
            w = predict();
            total++; if (a_ack !== (w == 1) || b_ack !== (w == 2) || ram_ce !== (w != 0)) begin
                bad++; $display("FAIL rand_grant cycle %0d got a=%b b=%b ce=%b want winner %0d", i, a_ack, b_ack, ram_ce, w); end
            total++;
            if (ram_we !== ((w == 1) ? a_we : (w == 2) ? b_we : 1'b0) ||
                ram_addr !== ((w == 1) ? a_addr : (w == 2) ? b_addr : '0) ||
                ram_data_i !== ((w == 1) ? a_wdata : (w == 2) ? b_wdata : '0)) begin
                bad++; $display("FAIL rand_bus cycle %0d got we=%b addr=%0d data=%h winner %0d", i, ram_we, ram_addr, ram_data_i, w); end
            total++; if (a_rvalid !== exp_av || b_rvalid !== exp_bv || ((exp_av || exp_bv) && rdata !== exp_rd)) begin
                bad++; $display("FAIL rand_read cycle %0d got av=%b bv=%b d=%h want %b %b %h", i, a_rvalid, b_rvalid, rdata, exp_av, exp_bv, exp_rd); end
            a_hold = a_req && (w != 1);
            b_hold = b_req && (w != 2);
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_reset_midflight();
        a_req = 1; a_we = 0; a_addr = 6'd7;
        #1;
        total++; if (a_ack !== 1'b1) begin bad++; $display("FAIL mid_pre_ack got %b want 1", a_ack); end
        rst = 1;
        #1;
        total++; if (a_ack !== 1'b0 || ram_ce !== 1'b0) begin bad++; $display("FAIL mid_rst_ce got ack=%b ce=%b want 0 0", a_ack, ram_ce); end
        tick();
        total++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin bad++; $display("FAIL mid_rvalid got %b%b want 00", a_rvalid, b_rvalid); end
        rst = 0;
        a_req = 1; b_req = 1; a_lock = 0; b_lock = 0;
        #1;
        total++; if (a_ack !== 1'b1 || b_ack !== 1'b0) begin bad++; $display("FAIL mid_first_tie got a=%b b=%b want 1 0", a_ack, b_ack); end
        tick();
        idle();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = {$urandom, $urandom};
            ref_mem[i] = mem[i];
        end
        model_reset();
        @(negedge clk);
        test_reset();
        test_single_read();
        test_alternate();
        test_wrap();
        test_burst();
        test_owner_drop();
        test_random();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
